// File: rtl/fl_sink_pkg.sv
// Shared types and constants for the FrameLink sink checker: FSM states,
// error codes and the throttle LFSR polynomial.
package fl_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PART = 2'd1,
    ST_GAP     = 2'd2
  } fl_state_e;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_SOF_NOT_IDLE = 3'd1;
  localparam logic [2:0] ERR_IDLE_NO_SOF  = 3'd2;
  localparam logic [2:0] ERR_SOP_IN_PART  = 3'd3;
  localparam logic [2:0] ERR_EOF_NO_EOP   = 3'd4;
  localparam logic [2:0] ERR_GAP_NO_SOP   = 3'd5;
  localparam logic [2:0] ERR_SOF_NO_SOP   = 3'd6;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fl_sink_checker_if.sv
// FrameLink receive bus between a frame source (master) and the sink checker (slave).
interface fl_sink_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int REM_W      = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
);
  // A word moves only in a cycle where rx_src_rdy_n and rx_dst_rdy_n are both
  // low at the rising edge; the source holds word and flags until that happens.
  logic [DATA_WIDTH-1:0] rx_data;
  logic [REM_W-1:0]      rx_rem;
  logic                  rx_sof_n;
  logic                  rx_eof_n;
  logic                  rx_sop_n;
  logic                  rx_eop_n;
  logic                  rx_src_rdy_n;
  logic                  rx_dst_rdy_n;

  modport master (
    output rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n,
    input  rx_dst_rdy_n
  );

  modport slave (
    input  rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n,
    output rx_dst_rdy_n
  );
endinterface

// File: rtl/fl_sink_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to generate pseudo-random back-pressure.
module fl_sink_lfsr
  import fl_sink_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= lfsr_next(state);
  end

endmodule

// File: rtl/fl_sink_checker.sv
// FrameLink sink that accepts words, counts words/frames and flags protocol errors.
// Optional pseudo-random back-pressure is compiled in with FL_SINK_THROTTLE_EN.
module fl_sink_checker
  import fl_sink_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  fl_sink_checker_if.slave    rx,
  input  logic                enable,
  input  logic                throttle,
  input  logic                clr,
  output logic [31:0]         frame_cnt,
  output logic [31:0]         word_cnt,
  output logic                err,
  output logic [2:0]          err_code,
  output logic                busy,
  output fl_state_e           state_dbg
);

  fl_state_e  state, state_nxt;
  logic [2:0] code;
  logic       sof, eof, sop, eop, xfer, frame_end;

  assign sof  = ~rx.rx_sof_n;
  assign eof  = ~rx.rx_eof_n;
  assign sop  = ~rx.rx_sop_n;
  assign eop  = ~rx.rx_eop_n;
  assign xfer = ~rx.rx_src_rdy_n & ~rx.rx_dst_rdy_n;

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Payload and byte-remainder are carried but never checked.
  logic [DATA_WIDTH-1:0] unused_data;
  logic                  unused_rem;
  assign unused_data = rx.rx_data;
  assign unused_rem  = ^rx.rx_rem;

`ifdef FL_SINK_THROTTLE_EN
  logic [15:0] lfsr_state;
  logic [14:0] unused_lfsr;

  fl_sink_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  assign unused_lfsr = lfsr_state[15:1];

  always_ff @(posedge clk) begin
    if (reset) rx.rx_dst_rdy_n <= 1'b1;
    else       rx.rx_dst_rdy_n <= ~enable | (throttle & lfsr_state[0]);
  end
`else
  logic        unused_throttle;
  logic [15:0] unused_seed;
  assign unused_throttle = throttle;
  assign unused_seed     = LFSR_SEED;

  always_ff @(posedge clk) begin
    if (reset) rx.rx_dst_rdy_n <= 1'b1;
    else       rx.rx_dst_rdy_n <= ~enable;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Later assignments override earlier ones, so the lowest violated code wins.
  // The next state follows the word's own flags whether or not it is legal.
  always_comb begin
    code      = ERR_NONE;
    state_nxt = state;
    if (sof & ~sop)                code = ERR_SOF_NO_SOP;
    if ((state == ST_GAP) & ~sop)  code = ERR_GAP_NO_SOP;
    if (eof & ~eop)                code = ERR_EOF_NO_EOP;
    if (sop & (state == ST_IN_PART)) code = ERR_SOP_IN_PART;
    if ((state == ST_IDLE) & ~sof) code = ERR_IDLE_NO_SOF;
    if (sof & (state != ST_IDLE))  code = ERR_SOF_NOT_IDLE;
    if (xfer) begin
      if (eof)      state_nxt = ST_IDLE;
      else if (eop) state_nxt = ST_GAP;
      else          state_nxt = ST_IN_PART;
    end
    frame_end = xfer & eof & (code == ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      frame_cnt <= '0;
      word_cnt  <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (xfer) begin
      word_cnt <= word_cnt + {31'd0, (word_cnt != 32'hFFFF_FFFF)};
      if (frame_end)
        frame_cnt <= frame_cnt + {31'd0, (frame_cnt != 32'hFFFF_FFFF)};
      if ((code != ERR_NONE) && !err) begin
        err      <= 1'b1;
        err_code <= code;
      end
    end
  end

endmodule

// File: tb/tb_fl_sink_checker.sv
// Directed bench for fl_sink_checker: legal frames, error coding, CLR/RESET and back-pressure.
module tb_fl_sink_checker;
  import fl_sink_pkg::*;

  localparam int          DW   = 64;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic throttle = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] frame_cnt, word_cnt;
  logic        err, busy;
  logic [2:0]  err_code;
  fl_state_e   state_dbg;

  fl_sink_checker_if #(.DATA_WIDTH(DW)) rx ();

  fl_sink_checker #(.DATA_WIDTH(DW), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .enable    (enable),
    .throttle  (throttle),
    .clr       (clr),
    .frame_cnt (frame_cnt),
    .word_cnt  (word_cnt),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ready model, independently stepping the 16/14/13/11 polynomial.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] ref_lfsr;
  logic        exp_rdy_n;
  bit          chk_rdy = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      ref_lfsr  <= SEED;
      exp_rdy_n <= 1'b1;
    end else begin
      ref_lfsr  <= ref_step(ref_lfsr);
`ifdef FL_SINK_THROTTLE_EN
      exp_rdy_n <= ~enable | (throttle & ref_lfsr[0]);
`else
      exp_rdy_n <= ~enable;
`endif
    end
  end

  always @(negedge clk)
    if (chk_rdy) check_eq("rx_dst_rdy_n", {31'd0, rx.rx_dst_rdy_n}, {31'd0, exp_rdy_n});

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    rx.rx_src_rdy_n = 1'b1;
    rx.rx_sof_n = 1'b1;
    rx.rx_eof_n = 1'b1;
    rx.rx_sop_n = 1'b1;
    rx.rx_eop_n = 1'b1;
  endtask

  // Present one word (active-high flag arguments) and hold it until accepted.
  task automatic send(input logic sof, input logic sop, input logic eop, input logic eof);
    int waited = 0;
    bit done = 1'b0;
    rx.rx_data      = {$urandom, $urandom};
    rx.rx_rem       = 3'($urandom_range(0, 7));
    rx.rx_sof_n     = ~sof;
    rx.rx_sop_n     = ~sop;
    rx.rx_eop_n     = ~eop;
    rx.rx_eof_n     = ~eof;
    rx.rx_src_rdy_n = 1'b0;
    while (!done && waited < 64) begin
      done = (rx.rx_dst_rdy_n == 1'b0);
      tick();
      waited++;
    end
    idle_bus();
    if (!done) check_eq("xfer_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_bus();
    rx.rx_data = '0;
    rx.rx_rem  = '0;
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    check_eq("rst_rdy_n",  {31'd0, rx.rx_dst_rdy_n}, 32'd1);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_frames", frame_cnt, 32'd0);
    check_eq("rst_words",  word_cnt, 32'd0);
    check_eq("rst_err",    {31'd0, err}, 32'd0);
    check_eq("rst_code",   {29'd0, err_code}, 32'd0);
    check_eq("rst_state",  {30'd0, state_dbg}, 32'd0);

    reset = 1'b0;
    tick();
    check_eq("rdy_after_reset", {31'd0, rx.rx_dst_rdy_n}, 32'd0);
    chk_rdy = 1'b1;

    // Three legal 4-word single-part frames.
    for (int i = 1; i <= 12; i++) exp_q.push_back(i);
    for (int f = 0; f < 3; f++)
      for (int w = 0; w < 4; w++) begin
        send(w == 0, w == 0, w == 3, w == 3);
        check_eq("word_cnt_run", word_cnt, exp_q.pop_front());
      end
    check_eq("frames3", frame_cnt, 32'd3);
    check_eq("words12", word_cnt, 32'd12);
    check_eq("err_legal", {31'd0, err}, 32'd0);

    // Two-part frame.
    send(1, 1, 0, 0);
    check_eq("busy_part1", {31'd0, busy}, 32'd1);
    check_eq("st_in_part", {30'd0, state_dbg}, {30'd0, ST_IN_PART});
    send(0, 0, 1, 0);
    check_eq("busy_gap", {31'd0, busy}, 32'd1);
    check_eq("st_gap", {30'd0, state_dbg}, {30'd0, ST_GAP});
    send(0, 1, 0, 0);
    check_eq("busy_part2", {31'd0, busy}, 32'd1);
    send(0, 0, 1, 1);
    check_eq("busy_after_eof", {31'd0, busy}, 32'd0);
    check_eq("frames4", frame_cnt, 32'd4);
    check_eq("err_2part", {31'd0, err}, 32'd0);

    // SOF inside a part, then SOP inside a part: first code is kept.
    send(1, 1, 0, 0);
    send(1, 1, 0, 0);
    check_eq("err_sof_in_part", {31'd0, err}, 32'd1);
    check_eq("code_sof_in_part", {29'd0, err_code}, 32'd1);
    check_eq("resync_in_part", {30'd0, state_dbg}, {30'd0, ST_IN_PART});
    send(0, 1, 0, 0);
    check_eq("code_kept", {29'd0, err_code}, 32'd1);
    send(0, 0, 1, 1);

    pulse_clr();
    check_eq("clr_frames", frame_cnt, 32'd0);
    check_eq("clr_words", word_cnt, 32'd0);
    check_eq("clr_err", {31'd0, err}, 32'd0);
    check_eq("clr_code", {29'd0, err_code}, 32'd0);

    // EOF without EOP inside the gap (codes 4 and 5 both apply).
    send(1, 1, 0, 0);
    send(0, 0, 1, 0);
    send(0, 0, 0, 1);
    check_eq("code_eof_no_eop", {29'd0, err_code}, 32'd4);
    check_eq("resync_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check_eq("frames_unchanged", frame_cnt, 32'd0);
    check_eq("words3", word_cnt, 32'd3);

    // SOF without SOP.
    pulse_clr();
    send(1, 0, 0, 0);
    check_eq("code_sof_no_sop", {29'd0, err_code}, 32'd6);
    send(0, 0, 1, 1);

    // One-word frame, then a bare EOF in IDLE (codes 2 and 4 both apply).
    pulse_clr();
    send(1, 1, 1, 1);
    check_eq("one_word_frame", frame_cnt, 32'd1);
    check_eq("one_word_err", {31'd0, err}, 32'd0);
    check_eq("one_word_busy", {31'd0, busy}, 32'd0);
    send(0, 0, 0, 1);
    check_eq("code_idle_priority", {29'd0, err_code}, 32'd2);

    // CLR coincident with the EOF transfer of frame 5.
    pulse_clr();
    for (int i = 0; i < 4; i++) send(1, 1, 1, 1);
    check_eq("frames_before_clr", frame_cnt, 32'd4);
    send(1, 1, 0, 0);
    clr = 1'b1;
    send(0, 0, 1, 1);
    clr = 1'b0;
    check_eq("clr_eof_frames", frame_cnt, 32'd0);
    check_eq("clr_eof_words", word_cnt, 32'd0);
    check_eq("clr_eof_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    send(1, 1, 1, 1);
    check_eq("post_clr_frames", frame_cnt, 32'd1);
    check_eq("post_clr_err", {31'd0, err}, 32'd0);

    // ENABLE low blocks transfers.
    enable = 1'b0;
    tick();
    tick();
    check_eq("disabled_rdy_n", {31'd0, rx.rx_dst_rdy_n}, 32'd1);
    rx.rx_sof_n = 1'b0;
    rx.rx_sop_n = 1'b0;
    rx.rx_src_rdy_n = 1'b0;
    repeat (3) tick();
    idle_bus();
    check_eq("disabled_words", word_cnt, 32'd1);
    enable = 1'b1;
    tick();

    // 100 one-word frames with THROTTLE requested.
    pulse_clr();
    throttle = 1'b1;
    for (int i = 0; i < 100; i++) send(1, 1, 1, 1);
    throttle = 1'b0;
    check_eq("throttle_frames", frame_cnt, 32'd100);
    check_eq("throttle_words", word_cnt, 32'd100);
    check_eq("throttle_err", {31'd0, err}, 32'd0);

    // RESET mid-frame, then a word that would only be legal in a gap.
    send(1, 1, 0, 0);
    send(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_frames", frame_cnt, 32'd0);
    check_eq("midrst_words", word_cnt, 32'd0);
    reset = 1'b0;
    tick();
    send(0, 1, 0, 0);
    check_eq("post_rst_err", {31'd0, err}, 32'd1);
    check_eq("post_rst_code", {29'd0, err_code}, 32'd2);
    check_eq("post_rst_frames", frame_cnt, 32'd0);

    tick();
    chk_rdy = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fl_sink_checker.md
FL_SINK_CHECKER -- requirements
Module: fl_sink_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 64, RX data width in bits; legal values are 8, 16, 32, 64 and 128.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, throttle LFSR reset value; a value of 0 is illegal.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 RX_DATA  in  DATA_WIDTH  FrameLink data; ignored by checks.
REQ-007 RX_REM  in  log2(DATA_WIDTH/8)  valid-byte index of last word; ignored by checks.
REQ-008 RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  1 each  active-low frame/part delimiters.
REQ-009 RX_SRC_RDY_N  in  1  active-low source ready.
REQ-010 RX_DST_RDY_N  out  1  active-low sink ready; registered.
REQ-011 ENABLE  in  1  when 0 the sink SHALL NOT accept words.
REQ-012 THROTTLE  in  1  requests pseudo-random back-pressure.
REQ-013 CLR  in  1  synchronous clear of counters, ERR and ERR_CODE.
REQ-014 FRAME_CNT  out  32  count of legally terminated frames.
REQ-015 WORD_CNT  out  32  count of transferred words.
REQ-016 ERR  out  1  sticky protocol-error flag.
REQ-017 ERR_CODE  out  3  code of first error since reset/CLR.
REQ-018 BUSY  out  1  high while FSM is not IDLE.

Function
REQ-019 Transfer = RX_SRC_RDY_N=0 and RX_DST_RDY_N=0 in the same cycle; only transfers SHALL affect FSM, counters and checks.
REQ-020 FSM states: IDLE (expect SOF+SOP), IN_PART (expect EOP), GAP (between parts; expect SOP without SOF).
REQ-021 Legal transitions: IDLE->IN_PART on SOF&SOP word without EOP; IN_PART->GAP on EOP without EOF; any->IDLE on legal EOF&EOP word; GAP->IN_PART on SOP word without EOP.
REQ-022 A single word carrying SOF, SOP, EOP and EOF SHALL be a legal one-word frame.
REQ-023 Error codes: 1 SOF while not IDLE; 2 word in IDLE without SOF; 3 SOP while IN_PART; 4 EOF without EOP; 5 word in GAP without SOP; 6 SOF without SOP.
REQ-024 When one word violates several rules, ERR_CODE SHALL record the lowest code.
REQ-025 On an error, the FSM SHALL resynchronise from the word's flags: EOF -> IDLE, else EOP -> GAP, else IN_PART; FRAME_CNT SHALL NOT increment.
REQ-026 ERR SHALL set the cycle after the first erroneous transfer; ERR_CODE SHALL be written only when ERR=0.
REQ-027 WORD_CNT and FRAME_CNT SHALL update one cycle after the transfer and SHALL saturate at 32'hFFFFFFFF.
REQ-028 CLR with a simultaneous transfer: clear wins; that transfer is not counted and not error-checked; FSM state still advances.
REQ-029 RX_DST_RDY_N next value = NOT ENABLE OR (THROTTLE AND lfsr[0]) when throttling is compiled in; otherwise NOT ENABLE.
REQ-030 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11 and SHALL advance every cycle.

Reset
REQ-031 RESET SHALL set RX_DST_RDY_N=1, FSM=IDLE, BUSY=0, FRAME_CNT=0, WORD_CNT=0, ERR=0, ERR_CODE=0 and LFSR=LFSR_SEED.
REQ-032 RESET mid-frame SHALL discard the partial frame; the first word after reset SHALL be checked as in IDLE.

Configuration
REQ-033 Macro FL_SINK_THROTTLE_EN: when defined, the LFSR and THROTTLE are active per REQ-029/030.
REQ-034 When the macro is undefined, the LFSR SHALL NOT be instantiated, THROTTLE SHALL be ignored and RX_DST_RDY_N = registered NOT ENABLE.

Structure
REQ-035 Package fl_sink_pkg SHALL hold the state enum, ERR_CODE constants (NONE=0 to SOF_NO_SOP=6) and LFSR tap constant.
REQ-036 The LFSR SHALL be a sub-module fl_sink_lfsr (SEED parameter; output 16-bit state).

Verification
REQ-037 Three legal frames of 4 words each, single part, ENABLE=1, THROTTLE=0 -> FRAME_CNT=3, WORD_CNT=12, ERR=0, RX_DST_RDY_N=0 from the 2nd cycle after reset.
REQ-038 Two-part frame (SOF+SOP, EOP, SOP, EOP+EOF) -> FRAME_CNT=1, BUSY=1 during the frame, BUSY=0 after the EOF word.
REQ-039 Word with SOF inside IN_PART, then a word with SOP inside IN_PART -> ERR=1, ERR_CODE=1 (the first error is kept).
REQ-040 EOF without EOP in GAP -> ERR_CODE=4, FSM=IDLE, FRAME_CNT unchanged.
REQ-041 THROTTLE=1 (macro defined), 100 one-word frames -> FRAME_CNT=100, ERR=0, RX_DST_RDY_N matches a reference LFSR seeded 16'hACE1.
REQ-042 CLR asserted on the EOF transfer of frame 5 -> FRAME_CNT=0, WORD_CNT=0 next cycle; RESET mid-frame then a GAP-style word -> ERR_CODE=2.
